// File: rtl/audio_fetch.sv
// ---------------------------------------------------------------------------
// audio_fetch
//   Audio sample DMA stage in front of the audio mixer. A rising edge on the
//   mixer fetch flag latches a word address and memory select, issues one
//   arbitrated read to VRAM or TILE memory, and holds the returned word stable
//   on the mixer's sample-word input. Fetches that the mixer gives up on
//   (fetch flag falls while the read is still outstanding) are flagged.
//
// Parameters
//   ADDR_W       word address width
//   DATA_W       sample word width
//   MEM_LATENCY  cycles from the grant cycle to valid read data (1..3)
//
// Ports
//   clk            pixel clock
//   reset_n_i      asynchronous active-low reset
//   fetch_i        mixer fetch flag (level); rising edge requests a word
//   fetch_addr_i   word address, sampled on the fetch_i rising edge
//   tile_sel_i     0 = VRAM, 1 = TILE memory, sampled with the address
//   mem_req_o      read request to the memory arbiter
//   mem_tile_o     memory select for the request
//   mem_addr_o     read address
//   mem_grant_i    arbiter grant, only looked at while requesting
//   mem_data_i     read data, valid MEM_LATENCY cycles after the grant cycle
//   word_o         sample word to the mixer
//   word_valid_o   word_o holds data for the most recent request
//   late_o         one-cycle pulse: fetch_i fell with its request outstanding
//
// Optional build macro AUDIO_FETCH_STATS_EN adds:
//   stats_clr_i    synchronous clear of late_count_o (wins over an increment)
//   late_count_o   saturating count of late_o pulses
// ---------------------------------------------------------------------------
module audio_fetch #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              fetch_i,
  input  logic [ADDR_W-1:0] fetch_addr_i,
  input  logic              tile_sel_i,
  output logic              mem_req_o,
  output logic              mem_tile_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_grant_i,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic [DATA_W-1:0] word_o,
  output logic              word_valid_o,
  output logic              late_o
`ifdef AUDIO_FETCH_STATS_EN
  ,
  input  logic              stats_clr_i,
  output logic [7:0]        late_count_o
`endif
);

  localparam int LAT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state;
  state_t              state_d;

  logic                fetch_q;
  logic                fetch_evt;
  logic                fetch_fall;
  logic [ADDR_W-1:0]   req_addr;
  logic                req_tile;
  logic                pending;
  logic                pending_d;
  logic [LAT_W-1:0]    lat_cnt;
  logic [LAT_W-1:0]    lat_d;
  logic                req_d;
  logic [ADDR_W-1:0]   addr_d;
  logic                tile_d;
  logic [ADDR_W-1:0]   nxt_addr;
  logic                nxt_tile;
  logic                capture;
  logic                keep;
  logic                late_d;

  assign fetch_evt  = fetch_i & ~fetch_q;
  assign fetch_fall = fetch_q & ~fetch_i;

  // An event on the same edge as an issue from IDLE must use the fresh
  // address, since the request registers only update on that edge.
  assign nxt_addr = fetch_evt ? fetch_addr_i : req_addr;
  assign nxt_tile = fetch_evt ? tile_sel_i   : req_tile;

  // A capture is only delivered if no newer event arrived while it was in
  // flight; pending marks exactly that case.
  assign keep   = capture & ~pending;
  assign late_d = fetch_fall & ((state != IDLE) | pending);

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d   = state;
    req_d     = mem_req_o;
    addr_d    = mem_addr_o;
    tile_d    = mem_tile_o;
    pending_d = pending;
    lat_d     = lat_cnt;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (fetch_evt || pending) begin
          req_d     = 1'b1;
          addr_d    = nxt_addr;
          tile_d    = nxt_tile;
          pending_d = 1'b0;
          state_d   = REQ;
        end
      end
      REQ: begin
        if (mem_grant_i) begin
          req_d   = 1'b0;
          lat_d   = LAT_W'(MEM_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          capture = 1'b1;
          state_d = IDLE;
        end else begin
          lat_d = lat_cnt - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Queue depth of one: a busy-time event replaces whatever was queued.
    if (fetch_evt && (state != IDLE)) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      fetch_q      <= 1'b0;
      pending      <= 1'b0;
      lat_cnt      <= '0;
      mem_req_o    <= 1'b0;
      mem_addr_o   <= '0;
      mem_tile_o   <= 1'b0;
      req_addr     <= '0;
      req_tile     <= 1'b0;
      word_o       <= '0;
      word_valid_o <= 1'b0;
      late_o       <= 1'b0;
    end else begin
      fetch_q    <= fetch_i;
      pending    <= pending_d;
      lat_cnt    <= lat_d;
      mem_req_o  <= req_d;
      mem_addr_o <= addr_d;
      mem_tile_o <= tile_d;
      late_o     <= late_d;
      if (fetch_evt) begin
        req_addr <= fetch_addr_i;
        req_tile <= tile_sel_i;
      end
      if (keep) begin
        word_o <= mem_data_i;
      end
      // A new event invalidates the word even if a capture lands this edge.
      if (fetch_evt) begin
        word_valid_o <= 1'b0;
      end else if (keep) begin
        word_valid_o <= 1'b1;
      end
    end
  end

`ifdef AUDIO_FETCH_STATS_EN
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      late_count_o <= 8'h00;
    end else if (stats_clr_i) begin
      late_count_o <= 8'h00;
    end else if (late_d && (late_count_o != 8'hFF)) begin
      late_count_o <= late_count_o + 8'h01;
    end
  end
`endif

  a_req_held: assert property (@(posedge clk) disable iff (!reset_n_i)
    (mem_req_o && !mem_grant_i) |=> mem_req_o);

  a_addr_stable: assert property (@(posedge clk) disable iff (!reset_n_i)
    (mem_req_o && !mem_grant_i) |=> ($stable(mem_addr_o) && $stable(mem_tile_o)));

endmodule

// File: tb/tb_audio_fetch.sv
// ---------------------------------------------------------------------------
// tb_audio_fetch
//   Directed bench for audio_fetch (MEM_LATENCY = 1). The bench acts as the
//   mixer and as the memory arbiter; inputs change on the falling edge and
//   outputs are sampled on the falling edge, away from the active edge.
//   Stats checks are included when AUDIO_FETCH_STATS_EN is defined.
// ---------------------------------------------------------------------------
module tb_audio_fetch;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  logic              clk;
  logic              reset_n_i;
  logic              fetch_i;
  logic [ADDR_W-1:0] fetch_addr_i;
  logic              tile_sel_i;
  logic              mem_req_o;
  logic              mem_tile_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_grant_i;
  logic [DATA_W-1:0] mem_data_i;
  logic [DATA_W-1:0] word_o;
  logic              word_valid_o;
  logic              late_o;
`ifdef AUDIO_FETCH_STATS_EN
  logic              stats_clr_i;
  logic [7:0]        late_count_o;
`endif

  int checks;
  int failures;

  audio_fetch #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .MEM_LATENCY (1)
  ) dut (
    .clk          (clk),
    .reset_n_i    (reset_n_i),
    .fetch_i      (fetch_i),
    .fetch_addr_i (fetch_addr_i),
    .tile_sel_i   (tile_sel_i),
    .mem_req_o    (mem_req_o),
    .mem_tile_o   (mem_tile_o),
    .mem_addr_o   (mem_addr_o),
    .mem_grant_i  (mem_grant_i),
    .mem_data_i   (mem_data_i),
    .word_o       (word_o),
    .word_valid_o (word_valid_o),
    .late_o       (late_o)
`ifdef AUDIO_FETCH_STATS_EN
    ,
    .stats_clr_i  (stats_clr_i),
    .late_count_o (late_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks       = 0;
    failures     = 0;
    reset_n_i    = 1'b0;
    fetch_i      = 1'b0;
    fetch_addr_i = '0;
    tile_sel_i   = 1'b0;
    mem_grant_i  = 1'b0;
    mem_data_i   = '0;
`ifdef AUDIO_FETCH_STATS_EN
    stats_clr_i  = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);

    // Reset state
    chk("rst_req",   mem_req_o,    0);
    chk("rst_addr",  mem_addr_o,   0);
    chk("rst_tile",  mem_tile_o,   0);
    chk("rst_word",  word_o,       0);
    chk("rst_valid", word_valid_o, 0);
    chk("rst_late",  late_o,       0);
`ifdef AUDIO_FETCH_STATS_EN
    chk("rst_cnt",   late_count_o, 0);
`endif
    reset_n_i = 1'b1;

    // Basic read, immediate grant: word lands on the 3rd edge
    fetch_i = 1'b1; fetch_addr_i = 16'h1234; tile_sel_i = 1'b0;
    mem_grant_i = 1'b1; mem_data_i = 16'hA55A;
    tick();
    chk("t1_req",   mem_req_o,    1);
    chk("t1_addr",  mem_addr_o,   16'h1234);
    chk("t1_tile",  mem_tile_o,   0);
    chk("t1_valid0", word_valid_o, 0);
    tick();
    chk("t1_reqdrop", mem_req_o,  0);
    chk("t1_valid1", word_valid_o, 0);
    tick();
    chk("t1_word",  word_o,       16'hA55A);
    chk("t1_valid", word_valid_o, 1);
    mem_grant_i = 1'b0;

    // Grant withheld for 5 cycles, TILE memory
    fetch_i = 1'b0;
    tick();
    fetch_i = 1'b1; fetch_addr_i = 16'h0100; tile_sel_i = 1'b1;
    tick();
    chk("t2_valid_clr", word_valid_o, 0);
    chk("t2_word_hold", word_o, 16'hA55A);
    for (int i = 0; i < 5; i++) begin
      chk("t2_req",  mem_req_o,  1);
      chk("t2_addr", mem_addr_o, 16'h0100);
      chk("t2_tile", mem_tile_o, 1);
      tick();
    end
    chk("t2_req5", mem_req_o, 1);
    mem_grant_i = 1'b1; mem_data_i = 16'hBEEF;
    tick();
    chk("t2_reqdrop", mem_req_o, 0);
    chk("t2_word_inflight", word_o, 16'hA55A);
    mem_grant_i = 1'b0;
    tick();
    chk("t2_word",  word_o,       16'hBEEF);
    chk("t2_valid", word_valid_o, 1);

    // fetch_i falls while in IDLE: no late; falls while in REQ: late pulse
    fetch_i = 1'b0;
    tick();
    chk("t3_nolate", late_o, 0);
    fetch_i = 1'b1; fetch_addr_i = 16'h0300; tile_sel_i = 1'b0;
    tick();
    chk("t3_req", mem_req_o, 1);
    fetch_i = 1'b0;
    tick();
    chk("t3_late", late_o, 1);
    tick();
    chk("t3_late_end", late_o, 0);
    mem_grant_i = 1'b1; mem_data_i = 16'h1111;
    tick();
    mem_grant_i = 1'b0;
    tick();
    chk("t3_word",  word_o,       16'h1111);
    chk("t3_valid", word_valid_o, 1);
`ifdef AUDIO_FETCH_STATS_EN
    chk("t3_cnt", late_count_o, 1);
`endif

    // Newer event while the read to 0200 is outstanding: 0200 data dropped
    fetch_i = 1'b1; fetch_addr_i = 16'h0200;
    tick();
    chk("t4_addr0", mem_addr_o, 16'h0200);
    fetch_i = 1'b0;
    tick();
    chk("t4_late", late_o, 1);
    fetch_i = 1'b1; fetch_addr_i = 16'h0201;
    tick();
    chk("t4_addr_hold", mem_addr_o, 16'h0200);
    mem_grant_i = 1'b1; mem_data_i = 16'h2222;
    tick();
    mem_grant_i = 1'b0; mem_data_i = 16'h0000;
    tick();
    chk("t4_discard_word",  word_o,       16'h1111);
    chk("t4_discard_valid", word_valid_o, 0);
    tick();
    chk("t4_rereq",  mem_req_o,  1);
    chk("t4_readdr", mem_addr_o, 16'h0201);
    mem_grant_i = 1'b1; mem_data_i = 16'h3333;
    tick();
    mem_grant_i = 1'b0;
    tick();
    chk("t4_word",  word_o,       16'h3333);
    chk("t4_valid", word_valid_o, 1);
`ifdef AUDIO_FETCH_STATS_EN
    chk("t4_cnt", late_count_o, 2);
`endif

    // Capture and new event on the same edge: word written, valid cleared
    fetch_i = 1'b0;
    tick();
    fetch_i = 1'b1; fetch_addr_i = 16'h0400; mem_grant_i = 1'b1; mem_data_i = 16'h4444;
    tick();
    fetch_i = 1'b0;
    tick();
    chk("t5_late", late_o, 1);
    fetch_i = 1'b1; fetch_addr_i = 16'h0500; mem_grant_i = 1'b0;
    tick();
    chk("t5_word",  word_o,       16'h4444);
    chk("t5_valid", word_valid_o, 0);
    tick();
    chk("t5_rereq",  mem_req_o,  1);
    chk("t5_readdr", mem_addr_o, 16'h0500);
    mem_grant_i = 1'b1; mem_data_i = 16'h5555;
    tick();
    mem_grant_i = 1'b0;
    tick();
    chk("t5_word2",  word_o,       16'h5555);
    chk("t5_valid2", word_valid_o, 1);

`ifdef AUDIO_FETCH_STATS_EN
    // Saturation and clear of the late counter
    for (int i = 0; i < 300; i++) begin
      fetch_i = 1'b1;
      tick();
      fetch_i = 1'b0;
      tick();
    end
    chk("t6_sat", late_count_o, 8'hFF);
    stats_clr_i = 1'b1;
    tick();
    stats_clr_i = 1'b0;
    chk("t6_clr", late_count_o, 0);
`endif

    // Asynchronous reset in the middle of WAIT
    reset_n_i = 1'b0;
    fetch_i   = 1'b0;
    #1;
    reset_n_i = 1'b1;
    tick();
    fetch_i = 1'b1; fetch_addr_i = 16'h0600; tile_sel_i = 1'b1;
    mem_grant_i = 1'b1; mem_data_i = 16'h6666;
    tick();
    chk("t7_req", mem_req_o, 1);
    tick();
    #2;
    reset_n_i = 1'b0;
    fetch_i   = 1'b0;
    #1;
    chk("t7_rst_req",   mem_req_o,    0);
    chk("t7_rst_addr",  mem_addr_o,   0);
    chk("t7_rst_tile",  mem_tile_o,   0);
    chk("t7_rst_word",  word_o,       0);
    chk("t7_rst_valid", word_valid_o, 0);
    chk("t7_rst_late",  late_o,       0);
    @(negedge clk);
    #2;
    reset_n_i = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t7_idle_req",  mem_req_o,    0);
      chk("t7_idle_word", word_o,       0);
      chk("t7_idle_valid", word_valid_o, 0);
    end
    fetch_i = 1'b1; fetch_addr_i = 16'h0700; tile_sel_i = 1'b0;
    tick();
    chk("t7_new_req",  mem_req_o,  1);
    chk("t7_new_addr", mem_addr_o, 16'h0700);
    mem_grant_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
